// File: rtl/spi_mosi_deserializer.sv
// rtl/spi_mosi_deserializer.sv - SPI slave MOSI word assembler with valid/ready holding register and sticky overrun
module spi_mosi_deserializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit SAMPLE_NEG = 1'b1,
  localparam int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclkPosEdge,
  input  logic             sclkNegEdge,
  input  logic             cs_n,
  input  logic             mosi,
  input  logic             rx_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             strobe;
  logic             sample;
  logic             last_bit;
  logic             complete;

  assign strobe   = SAMPLE_NEG ? sclkNegEdge : sclkPosEdge;
  assign sample   = ~cs_n & strobe;
  assign last_bit = (bit_count == CW'(WIDTH - 1));
  assign complete = sample & last_bit;

  // sr_next already contains the bit sampled this cycle, so it is the finished word on completion
  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], mosi};
    else           sr_next = {mosi, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (cs_n) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (sample) begin
      sr        <= sr_next;
      bit_count <= last_bit ? '0 : bit_count + CW'(1);
    end
  end

  // A completion always loads the holding register; a concurrent rx_ready consumes the old word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (complete) begin
      rx_data  <= sr_next;
      rx_valid <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               overrun <= 1'b0;
    else if (complete & rx_valid & ~rx_ready) overrun <= 1'b1;
    else if (ovr_clr)                         overrun <= 1'b0;
  end

endmodule
